// File: rtl/ad4003_spi_reader.sv
// AD4003 3-wire turbo-mode reader: SCK master and MSB-first SDO deserialiser.
// Latency: o_DV is registered 2*DATA_BITS*CLK_DIV clk cycles after the start edge is registered.
// Backpressure: none; a start edge while busy is dropped and flagged on o_overrun.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_L      synchronous reset, active low; aborts any frame in progress
//   i_start    start_conv from the CNV generator; its rising edge starts a frame
//   i_sdo      ADC SDO, already synchronised
//   o_sck      ADC SCK, idle low, registered (also fed back to the CNV generator)
//   o_data     last completed sample; held until the next completed frame
//   o_DV       1-cycle pulse when o_data updates
//   o_busy     high while a frame is being shifted
//   o_overrun  1-cycle pulse, start edge ignored because a frame was in progress
//   o_timeout  1-cycle pulse, frame aborted after TIMEOUT cycles
//
// Build option: define SIGN_EXT_EN to widen o_data to 32 bits, sign-extended
// from the ADC's two's complement sample; otherwise o_data is the raw DATA_BITS word.

module ad4003_spi_reader #(
  parameter int DATA_BITS = 18,
  parameter int CLK_DIV   = 2,
  parameter int TIMEOUT   = 1000
) (
  input  logic                 clk,
  input  logic                 rst_L,
  input  logic                 i_start,
  input  logic                 i_sdo,
  output logic                 o_sck,
`ifdef SIGN_EXT_EN
  output logic [31:0]          o_data,
`else
  output logic [DATA_BITS-1:0] o_data,
`endif
  output logic                 o_DV,
  output logic                 o_busy,
  output logic                 o_overrun,
  output logic                 o_timeout
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_BITS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  logic                 start_q;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [7:0]           div_cnt;
  logic [TO_W-1:0]      to_cnt;

  // Only a rising edge of start_conv begins a frame; a held-high level does not.
  logic start_edge;
  assign start_edge = i_start & ~start_q;

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      to_cnt    <= '0;
      o_sck     <= 1'b0;
      o_data    <= '0;
      o_DV      <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      start_q   <= i_start;
      o_DV      <= 1'b0;
      o_overrun <= 1'b0;
      o_timeout <= 1'b0;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= SHIFT;
            o_busy  <= 1'b1;
            o_sck   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
          end
        end

        SHIFT: begin
          // Start edges during a frame are never queued, including the DV cycle.
          if (start_edge) o_overrun <= 1'b1;

          // to_cnt holds the number of SHIFT cycles already spent; this cycle
          // is the TIMEOUT-th one when it equals TIMEOUT-1.
          if (to_cnt == TO_LAST) begin
            o_sck     <= 1'b0;
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (!o_sck) begin
                // SCK rising: ADC data has been stable since the previous fall.
                o_sck     <= 1'b1;
                shift_reg <= {shift_reg[DATA_BITS-2:0], i_sdo};
                bit_cnt   <= bit_cnt + BIT_W'(1);
              end else begin
                o_sck <= 1'b0;
                // The frame closes on the falling edge after the last rise.
                if (bit_cnt == BIT_ALL) begin
`ifdef SIGN_EXT_EN
                  o_data <= {{(32-DATA_BITS){shift_reg[DATA_BITS-1]}}, shift_reg};
`else
                  o_data <= shift_reg;
`endif
                  o_DV   <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= IDLE;
                end
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad4003_spi_reader.sv
module tb_ad4003_spi_reader;

`ifdef SIGN_EXT_EN
  localparam int OUT_W = 32;
`else
  localparam int OUT_W = 18;
`endif

  logic clk;
  int   cyc;
  int   n_checks;
  int   n_fail;

  // Instance a: defaults (CLK_DIV=2, TIMEOUT=1000)
  logic rst_a, start_a, sdo_a, sck_a, dv_a, busy_a, ovr_a, to_a;
  logic [OUT_W-1:0] data_a;
  // Instance b: TIMEOUT=50
  logic rst_b, start_b, sdo_b, sck_b, dv_b, busy_b, ovr_b, to_b;
  logic [OUT_W-1:0] data_b;
  // Instance c: CLK_DIV=1
  logic rst_c, start_c, sdo_c, sck_c, dv_c, busy_c, ovr_c, to_c;
  logic [OUT_W-1:0] data_c;

  ad4003_spi_reader u_a (
    .clk(clk), .rst_L(rst_a), .i_start(start_a), .i_sdo(sdo_a), .o_sck(sck_a),
    .o_data(data_a), .o_DV(dv_a), .o_busy(busy_a), .o_overrun(ovr_a), .o_timeout(to_a));

  ad4003_spi_reader #(.TIMEOUT(50)) u_b (
    .clk(clk), .rst_L(rst_b), .i_start(start_b), .i_sdo(sdo_b), .o_sck(sck_b),
    .o_data(data_b), .o_DV(dv_b), .o_busy(busy_b), .o_overrun(ovr_b), .o_timeout(to_b));

  ad4003_spi_reader #(.CLK_DIV(1)) u_c (
    .clk(clk), .rst_L(rst_c), .i_start(start_c), .i_sdo(sdo_c), .o_sck(sck_c),
    .o_data(data_c), .o_DV(dv_c), .o_busy(busy_c), .o_overrun(ovr_c), .o_timeout(to_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC SDO model: MSB presented before the first SCK rise, next bit after each SCK fall.
  logic [17:0] pat_a, pat_c, sh_a, sh_c;
  int fall_a, base_a, rise_a, fall_c, base_c, rise_c;
  always @(negedge sck_a) fall_a <= fall_a + 1;
  always @(posedge sck_a) rise_a <= rise_a + 1;
  always @(negedge sck_c) fall_c <= fall_c + 1;
  always @(posedge sck_c) rise_c <= rise_c + 1;
  assign sh_a  = pat_a << (fall_a - base_a);
  assign sh_c  = pat_c << (fall_c - base_c);
  assign sdo_a = sh_a[17];
  assign sdo_c = sh_c[17];

  // Expected output word for an 18-bit ADC sample.
  function automatic logic [OUT_W-1:0] exp_word(input logic [17:0] s);
`ifdef SIGN_EXT_EN
    return {{14{s[17]}}, s};
`else
    return s;
`endif
  endfunction

  // Stimulus helper: one-cycle start pulse on instance a, then wait (bounded) for o_DV.
  task automatic run_frame_a(input logic [17:0] pat, output int t0, output int dv_cyc,
                             output int first_hi, output int rises, output logic busy_mid);
    int r0;
    @(negedge clk);
    pat_a   = pat;
    base_a  = fall_a;
    r0      = rise_a;
    start_a = 1'b1;
    t0      = cyc + 1;
    @(negedge clk);
    busy_mid = busy_a;
    start_a  = 1'b0;
    dv_cyc   = -1;
    first_hi = -1;
    for (int k = 0; k < 200 && dv_cyc < 0; k++) begin
      @(negedge clk);
      if (sck_a && first_hi < 0) first_hi = cyc;
      if (dv_a) dv_cyc = cyc;
    end
    rises = rise_a - r0;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    sdo_b = 1'b1;
    pat_a = '0; pat_c = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (sck_a !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck_a); end
    n_checks++; if (data_a !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_a); end
    n_checks++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", dv_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (ovr_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
    n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", to_a); end
    n_checks++;
    if ({sck_b, dv_b, busy_b, ovr_b, to_b, sck_c, dv_c, busy_c, ovr_c, to_c} !== 10'b0 ||
        data_b !== '0 || data_c !== '0) begin
      n_fail++;
      $display("FAIL reset_other_inst: b=%b%b%b%b%b c=%b%b%b%b%b want all 0",
               sck_b, dv_b, busy_b, ovr_b, to_b, sck_c, dv_c, busy_c, ovr_c, to_c);
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0, dv_cyc, first_hi, rises;
    logic busy_mid;
    run_frame_a(18'h2A5A5, t0, dv_cyc, first_hi, rises, busy_mid);
    n_checks++; if (dv_cyc !== t0 + 72) begin n_fail++; $display("FAIL basic_dv_time: got %0d want %0d", dv_cyc - t0, 72); end
    n_checks++; if (data_a !== exp_word(18'h2A5A5)) begin n_fail++; $display("FAIL basic_data: got %h want %h", data_a, exp_word(18'h2A5A5)); end
    n_checks++; if (rises !== 18) begin n_fail++; $display("FAIL basic_sck_rises: got %0d want 18", rises); end
    n_checks++; if (first_hi !== t0 + 2) begin n_fail++; $display("FAIL basic_first_rise: got %0d want %0d", first_hi - t0, 2); end
    n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL basic_busy_during: got %b want 1", busy_mid); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_dv: got %b want 0", busy_a); end
    @(negedge clk);
    n_checks++; if (dv_a !== 1'b0) begin n_fail++; $display("FAIL basic_dv_pulse_width: got %b want 0", dv_a); end
    n_checks++; if (busy_a !== 1'b0 || sck_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: busy=%b sck=%b want 0 0", busy_a, sck_a); end
  endtask

  task automatic test_sign_ext();
    int t0, dv_cyc, first_hi, rises;
    logic busy_mid;
    logic [OUT_W-1:0] e1, e2;
`ifdef SIGN_EXT_EN
    e1 = 32'hFFFE0001;
    e2 = 32'h0001FFFF;
`else
    e1 = 18'h20001;
    e2 = 18'h1FFFF;
`endif
    run_frame_a(18'h20001, t0, dv_cyc, first_hi, rises, busy_mid);
    n_checks++; if (data_a !== e1) begin n_fail++; $display("FAIL sext_negative: got %h want %h", data_a, e1); end
    run_frame_a(18'h1FFFF, t0, dv_cyc, first_hi, rises, busy_mid);
    n_checks++; if (data_a !== e2) begin n_fail++; $display("FAIL sext_positive: got %h want %h", data_a, e2); end
  endtask

  task automatic test_overrun();
    int t0, ovr_n, dv_n, ovr_at, dv_at;
    logic restart;
    logic [17:0] p;
    logic [OUT_W-1:0] got;
    p = 18'($urandom());
    ovr_n = 0; dv_n = 0; ovr_at = -1; dv_at = -1; restart = 1'b0; got = '0;
    @(negedge clk);
    pat_a   = p;
    base_a  = fall_a;
    start_a = 1'b1;
    t0      = cyc + 1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (ovr_a) begin ovr_n++; ovr_at = cyc; end
      if (dv_a) begin dv_n++; dv_at = cyc; got = data_a; end
      if (cyc > t0 + 72 && busy_a) restart = 1'b1;
      if (cyc == t0 + 9) start_a = 1'b0;
      if (cyc == t0 + 20) start_a = 1'b1;
    end
    start_a = 1'b0;
    n_checks++; if (ovr_n !== 1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", ovr_n); end
    n_checks++; if (ovr_at !== t0 + 21) begin n_fail++; $display("FAIL ovr_time: got %0d want %0d", ovr_at - t0, 21); end
    n_checks++; if (dv_n !== 1) begin n_fail++; $display("FAIL ovr_dv_count: got %0d want 1", dv_n); end
    n_checks++; if (dv_at !== t0 + 72) begin n_fail++; $display("FAIL ovr_dv_time: got %0d want %0d", dv_at - t0, 72); end
    n_checks++; if (got !== exp_word(p)) begin n_fail++; $display("FAIL ovr_data: got %h want %h", got, exp_word(p)); end
    n_checks++; if (restart !== 1'b0) begin n_fail++; $display("FAIL ovr_level_restart: got %b want 0", restart); end
  endtask

  task automatic test_reset_mid();
    int t0, dv_n, dv_cyc, first_hi, rises;
    logic busy_mid, sck_r, busy_r;
    logic [OUT_W-1:0] data_r;
    logic [17:0] p;
    dv_n = 0; sck_r = 1'bx; busy_r = 1'bx; data_r = 'x;
    @(negedge clk);
    pat_a   = 18'($urandom());
    base_a  = fall_a;
    start_a = 1'b1;
    t0      = cyc + 1;
    for (int k = 0; k < 101; k++) begin
      @(negedge clk);
      if (cyc == t0) start_a = 1'b0;
      if (dv_a) dv_n++;
      if (cyc == t0 + 30) begin sck_r = sck_a; busy_r = busy_a; data_r = data_a; rst_a = 1'b1; end
      if (cyc == t0 + 29) rst_a = 1'b0;
    end
    n_checks++; if (sck_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_sck: got %b want 0", sck_r); end
    n_checks++; if (busy_r !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_r); end
    n_checks++; if (data_r !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", data_r); end
    n_checks++; if (dv_n !== 0) begin n_fail++; $display("FAIL rstmid_no_dv: got %0d want 0", dv_n); end
    p = 18'($urandom());
    run_frame_a(p, t0, dv_cyc, first_hi, rises, busy_mid);
    n_checks++; if (dv_cyc !== t0 + 72) begin n_fail++; $display("FAIL rstmid_next_time: got %0d want %0d", dv_cyc - t0, 72); end
    n_checks++; if (data_a !== exp_word(p)) begin n_fail++; $display("FAIL rstmid_next_data: got %h want %h", data_a, exp_word(p)); end
    n_checks++; if (rises !== 18) begin n_fail++; $display("FAIL rstmid_next_rises: got %0d want 18", rises); end
  endtask

  task automatic test_timeout();
    int t0, to_n, to_at, dv_n;
    to_n = 0; to_at = -1; dv_n = 0;
    @(negedge clk);
    start_b = 1'b1;
    t0      = cyc + 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cyc == t0) start_b = 1'b0;
      if (to_b) begin to_n++; to_at = cyc; end
      if (dv_b) dv_n++;
    end
    n_checks++; if (to_n !== 1) begin n_fail++; $display("FAIL to_count: got %0d want 1", to_n); end
    n_checks++; if (to_at !== t0 + 50) begin n_fail++; $display("FAIL to_time: got %0d want %0d", to_at - t0, 50); end
    n_checks++; if (dv_n !== 0) begin n_fail++; $display("FAIL to_no_dv: got %0d want 0", dv_n); end
    n_checks++; if (data_b !== '0) begin n_fail++; $display("FAIL to_data_kept: got %h want 0", data_b); end
    n_checks++; if (sck_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL to_idle: sck=%b busy=%b want 0 0", sck_b, busy_b); end
  endtask

  task automatic test_back_to_back();
    int t0, dv_n, ovr_n, d1_at, d2_at, r0;
    logic [17:0] p1, p2;
    logic [OUT_W-1:0] d1, d2;
    p1 = 18'($urandom()); p2 = 18'($urandom());
    dv_n = 0; ovr_n = 0; d1_at = -1; d2_at = -1; d1 = 'x; d2 = 'x;
    @(negedge clk);
    pat_c   = p1;
    base_c  = fall_c;
    r0      = rise_c;
    start_c = 1'b1;
    t0      = cyc + 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cyc == t0 || cyc == t0 + 40) start_c = 1'b0;
      if (dv_c) begin
        if (dv_n == 0) begin d1_at = cyc; d1 = data_c; end
        else begin d2_at = cyc; d2 = data_c; end
        dv_n++;
      end
      if (ovr_c) ovr_n++;
      if (cyc == t0 + 39) begin pat_c = p2; base_c = fall_c; start_c = 1'b1; end
    end
    n_checks++; if (dv_n !== 2) begin n_fail++; $display("FAIL b2b_dv_count: got %0d want 2", dv_n); end
    n_checks++; if (d1_at !== t0 + 36) begin n_fail++; $display("FAIL b2b_dv1_time: got %0d want %0d", d1_at - t0, 36); end
    n_checks++; if (d2_at !== t0 + 76) begin n_fail++; $display("FAIL b2b_dv2_time: got %0d want %0d", d2_at - t0, 76); end
    n_checks++; if (d1 !== exp_word(p1)) begin n_fail++; $display("FAIL b2b_data1: got %h want %h", d1, exp_word(p1)); end
    n_checks++; if (d2 !== exp_word(p2)) begin n_fail++; $display("FAIL b2b_data2: got %h want %h", d2, exp_word(p2)); end
    n_checks++; if (ovr_n !== 0) begin n_fail++; $display("FAIL b2b_no_overrun: got %0d want 0", ovr_n); end
    n_checks++; if (rise_c - r0 !== 36) begin n_fail++; $display("FAIL b2b_sck_rises: got %0d want 36", rise_c - r0); end
  endtask

  task automatic test_random();
    int t0, dv_cyc, first_hi, rises;
    logic busy_mid;
    logic [17:0] p;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      p = 18'($urandom());
      run_frame_a(p, t0, dv_cyc, first_hi, rises, busy_mid);
      n_checks++; if (dv_cyc !== t0 + 72) begin n_fail++; $display("FAIL rand_dv_time[%0d]: got %0d want %0d", i, dv_cyc - t0, 72); end
      n_checks++; if (data_a !== exp_word(p)) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, data_a, exp_word(p)); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_sign_ext();
    test_overrun();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
